cp0_tlb_ctrl: RTL

CP0-side initiator for the 8-entry TLB. Owns the architectural TLB registers (Index, Random, EntryLo0, EntryLo1, PageMask, Wired, EntryHi) and accepts TLBR/TLBWI/TLBWR/TLBP requests from the pipeline over a valid/ready handshake. It sequences each request against the TLB's write, read and probe ports, and signals completion. It sits between the execute-stage CP0 logic and the TLB array, and supplies the current ASID to the translation paths.

---
 rtl/cp0_tlb_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/cp0_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_tlb_ctrl
//
// CP0-side controller for an 8-entry TLB. Holds the architectural TLB
// registers (Index, Random, EntryLo0, EntryLo1, PageMask, Wired, EntryHi),
// accepts TLBR/TLBWI/TLBWR/TLBP requests over a valid/ready handshake and
// sequences each one against the TLB's write, read and probe ports.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   op_valid/op_code         request (00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP)
//   op_ready                 high in IDLE; request accepted on valid && ready
//   op_done                  one-cycle completion pulse
//   mtc0_we/addr/wdata       CP0 register write
//   mfc0_addr/mfc0_rdata     CP0 register read (combinational, 0 if unmapped)
//   exc_tlb/exc_vaddr        TLB exception commit, loads EntryHi.VPN2
//   asid                     current ASID (EntryHi[7:0])
//   tlb_we/tlb_index         TLB write strobe and index
//   tlb_entryhi..entrylo1    write data, always the current register values
//   tlb_rd_index             TLB read index {2'b0, Index[2:0]}
//   tlb_rd_*                 TLB read data (combinational from the array)
//   tlb_probe_result         {29'b0, idx} on hit, 32'h8000_0000 on miss
// -----------------------------------------------------------------------------
module cp0_tlb_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    output logic        op_ready,
    output logic        op_done,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_rdata,
    input  logic        exc_tlb,
    input  logic [31:0] exc_vaddr,
    output logic [7:0]  asid,
    output logic        tlb_we,
    output logic [2:0]  tlb_index,
    output logic [31:0] tlb_entryhi,
    output logic [31:0] tlb_pagemask,
    output logic [31:0] tlb_entrylo0,
    output logic [31:0] tlb_entrylo1,
    output logic [4:0]  tlb_rd_index,
    input  logic [31:0] tlb_rd_entryhi,
    input  logic [31:0] tlb_rd_pagemask,
    input  logic [31:0] tlb_rd_entrylo0,
    input  logic [31:0] tlb_rd_entrylo1,
    input  logic [31:0] tlb_probe_result
);

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    localparam logic [4:0] A_INDEX    = 5'd0;
    localparam logic [4:0] A_RANDOM   = 5'd1;
    localparam logic [4:0] A_ENTRYLO0 = 5'd2;
    localparam logic [4:0] A_ENTRYLO1 = 5'd3;
    localparam logic [4:0] A_PAGEMASK = 5'd5;
    localparam logic [4:0] A_WIRED    = 5'd6;
    localparam logic [4:0] A_ENTRYHI  = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [2:0]  wr_idx_q;

    // Only the implemented fields are stored; everything else reads as 0.
    logic        index_p_q,  index_p_d;
    logic [2:0]  index_q,    index_d;
    logic [2:0]  random_q,   random_d;
    logic [2:0]  wired_q,    wired_d;
    logic [25:0] entrylo0_q, entrylo0_d;
    logic [25:0] entrylo1_q, entrylo1_d;
    logic [11:0] pagemask_q, pagemask_d;
    logic [18:0] vpn2_q,     vpn2_d;
    logic [7:0]  asid_q,     asid_d;

    logic wr_index, wr_lo0, wr_lo1, wr_pagemask, wr_wired, wr_entryhi;
    logic in_exec, do_tlbr, do_tlbp, is_write_op;

    assign wr_index    = mtc0_we && (mtc0_addr == A_INDEX);
    assign wr_lo0      = mtc0_we && (mtc0_addr == A_ENTRYLO0);
    assign wr_lo1      = mtc0_we && (mtc0_addr == A_ENTRYLO1);
    assign wr_pagemask = mtc0_we && (mtc0_addr == A_PAGEMASK);
    assign wr_wired    = mtc0_we && (mtc0_addr == A_WIRED);
    assign wr_entryhi  = mtc0_we && (mtc0_addr == A_ENTRYHI);

    assign in_exec     = (state_q == S_EXEC);
    assign is_write_op = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
    assign do_tlbr     = in_exec && (op_q == OP_TLBR);
    assign do_tlbp     = in_exec && (op_q == OP_TLBP);

    // Register next-state. Assignment order encodes the priority:
    // mtc0 first, exception overrides it, TLBR/TLBP capture overrides both.
    always_comb begin
        index_p_d  = index_p_q;
        index_d    = index_q;
        wired_d    = wired_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        pagemask_d = pagemask_q;
        vpn2_d     = vpn2_q;
        asid_d     = asid_q;

        if (wr_index)    index_d    = mtc0_wdata[2:0];
        if (wr_wired)    wired_d    = mtc0_wdata[2:0];
        if (wr_lo0)      entrylo0_d = mtc0_wdata[25:0];
        if (wr_lo1)      entrylo1_d = mtc0_wdata[25:0];
        if (wr_pagemask) pagemask_d = mtc0_wdata[24:13];
        if (wr_entryhi) begin
            vpn2_d = mtc0_wdata[31:13];
            asid_d = mtc0_wdata[7:0];
        end

        // Exception only replaces VPN2; a same-cycle mtc0 still sets ASID.
        if (exc_tlb) vpn2_d = exc_vaddr[31:13];

        if (do_tlbr) begin
            vpn2_d     = tlb_rd_entryhi[31:13];
            asid_d     = tlb_rd_entryhi[7:0];
            pagemask_d = tlb_rd_pagemask[24:13];
            entrylo0_d = tlb_rd_entrylo0[25:0];
            entrylo1_d = tlb_rd_entrylo1[25:0];
        end
        if (do_tlbp) begin
            index_p_d = tlb_probe_result[31];
            index_d   = tlb_probe_result[2:0];
        end

        // Random wraps to 7 on reaching Wired; a Wired write restarts it.
        if (wr_wired || (wired_q == 3'd7) || (random_q == wired_q))
            random_d = 3'd7;
        else
            random_d = random_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_p_q  <= 1'b0;
            index_q    <= 3'd0;
            random_q   <= 3'd7;
            wired_q    <= 3'd0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            pagemask_q <= '0;
            vpn2_q     <= '0;
            asid_q     <= '0;
        end else begin
            index_p_q  <= index_p_d;
            index_q    <= index_d;
            random_q   <= random_d;
            wired_q    <= wired_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            pagemask_q <= pagemask_d;
            vpn2_q     <= vpn2_d;
            asid_q     <= asid_d;
        end
    end

    // Request sequencer: IDLE -> EXEC -> RESP -> IDLE. The write index is
    // frozen at acceptance so a Random that keeps counting cannot move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_TLBR;
            wr_idx_q <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q     <= op_code;
                        wr_idx_q <= (op_code == OP_TLBWR) ? random_q : index_q;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC:  state_q <= S_RESP;
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A reset arriving mid-operation must not leak a write or a completion.
    assign op_ready = (state_q == S_IDLE);
    assign op_done  = (state_q == S_RESP) && !rst;
    assign tlb_we   = in_exec && is_write_op && !rst;
    assign tlb_index = wr_idx_q;

    // Write data comes straight from the registers, so an mtc0 in the EXEC
    // cycle only lands after the write edge.
    assign tlb_entryhi  = {vpn2_q, 5'b0, asid_q};
    assign tlb_pagemask = {7'b0, pagemask_q, 13'b0};
    assign tlb_entrylo0 = {6'b0, entrylo0_q};
    assign tlb_entrylo1 = {6'b0, entrylo1_q};
    assign tlb_rd_index = {2'b00, index_q};
    assign asid         = asid_q;

    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_addr)
            A_INDEX:    mfc0_rdata = {index_p_q, 28'b0, index_q};
            A_RANDOM:   mfc0_rdata = {29'b0, random_q};
            A_ENTRYLO0: mfc0_rdata = tlb_entrylo0;
            A_ENTRYLO1: mfc0_rdata = tlb_entrylo1;
            A_PAGEMASK: mfc0_rdata = tlb_pagemask;
            A_WIRED:    mfc0_rdata = {29'b0, wired_q};
            A_ENTRYHI:  mfc0_rdata = tlb_entryhi;
            default:    mfc0_rdata = '0;
        endcase
    end

    // Bits of the wide inputs that carry no architectural state.
    logic unused_bits;
    assign unused_bits = ^{exc_vaddr[12:0], tlb_rd_entryhi[12:8],
                           tlb_rd_pagemask[31:25], tlb_rd_pagemask[12:0],
                           tlb_rd_entrylo0[31:26], tlb_rd_entrylo1[31:26],
                           tlb_probe_result[30:3]};

endmodule
